pipemem_io: RTL and testbench
=============================

# pipemem_io

Memory-access stage of the pipelined CPU: the consumer of the execute stage's `ealu`/`eb`/`ern` results. Holds the EX/MEM pipeline register and routes each load/store to either the single-cycle data RAM or the memory-mapped I/O window. I/O accesses use a req/ack handshake with a timeout. The pipeline is stalled while an I/O access is outstanding.

## Interface
Parameters:
- `IO_BASE`, 24'hFFFFFF: upper 24 address bits selecting the I/O window (256 bytes).
- `TIMEOUT`, 16: maximum number of BUSY cycles waited for `io_ack`; range 1..65535.

Ports:
- `clock` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ealu` in 32: EX result; the address for loads/stores.
- `eb` in 32: EX store data.
- `ern` in 5: EX destination register.
- `ewreg`, `em2reg`, `ewmem` in 1 each: EX control bits (write reg, load, store).
- `malu` out 32, `mb` out 32, `mrn` out 5, `mm2reg` out 1: registered EX/MEM values.
- `mwreg` out 1: registered write-enable, gated by stall.
- `mmo` out 32: memory/I/O read data for WB.
- `stall` out 1: freeze request to IF/ID/EX and EX/MEM.
- `dmem_addr` out 32, `dmem_wdata` out 32, `dmem_we` out 1, `dmem_rdata` in 32: data RAM port; read is combinational.
- `io_addr` out 8, `io_wdata` out 32, `io_we` out 1, `io_req` out 1, `io_ack` in 1, `io_rdata` in 32: I/O bus.
- `io_err` out 1: sticky timeout flag.

## Operation
- EX/MEM register (`malu, mb, mrn, mwreg_r, mm2reg, mwmem`) loads on the rising edge when `stall`=0 and holds when `stall`=1.
- `mio` = (`malu[31:8]`==IO_BASE) & (`mm2reg` | `mwmem`). `eio` is the same test applied to the EX inputs.
- RAM path:
  - `dmem_addr`=`malu`, `dmem_wdata`=`mb`.
  - `dmem_we`=`mwmem` & ~`mio`.
  - `mmo`=`dmem_rdata` when ~`mio`.
- I/O path:
  - `io_addr`=`malu[7:0]`, `io_wdata`=`mb`.
  - `io_we`=`io_req` & `mwmem`.
  - `mmo`=`rdbuf` when `mio`.
- FSM states IDLE, BUSY, DONE; 16-bit counter `cnt`.
  - IDLE/DONE, on an edge where the register loads: if `eio`, go to BUSY with `cnt`←0; otherwise go to IDLE.
  - BUSY: `io_req`=1, `stall`=1.
    - If `io_ack`=1: `rdbuf`←`io_rdata` (writes also capture it, value unused) and go to DONE.
    - Else if `cnt`==TIMEOUT-1: `rdbuf`←32'hDEADBEEF, `io_err`←1, go to DONE.
    - Else `cnt`←`cnt`+1.
  - DONE: `io_req`=0, `stall`=0, `mmo`=`rdbuf`. The instruction completes into WB.
- `mwreg` = `mwreg_r` & ~`stall`. This sends a bubble to WB while an I/O access is outstanding, so each instruction writes back exactly once.
- `stall`=1 only in BUSY. RAM accesses never stall.
- `io_ack` outside BUSY is ignored.
- An ack arriving in the same cycle as the last timeout cycle takes priority: the read succeeds and `io_err` is unchanged.
- `io_err` clears only on reset.

## Timing
- Reset (async, immediate): all registers 0, state IDLE, `cnt`=0, `rdbuf`=0, `io_err`=0.
  - Outputs during reset: `stall`=0, `io_req`=0, `io_we`=0, `dmem_we`=0, `mwreg`=0, `mmo`=`dmem_rdata` (since `mio`=0).
- Reset asserted in BUSY aborts the access: `io_req` drops without waiting for a clock edge, and no writeback occurs.
- RAM load/store: zero extra cycles; `mmo` is valid in the same cycle the instruction is in MEM.
- I/O access with ack in the k-th BUSY cycle (k≥1):
  - Stall lasts k cycles, then one DONE cycle with `mwreg`=`mwreg_r`.
  - The next instruction loads at the end of the DONE cycle.
- I/O timeout: exactly TIMEOUT stall cycles, then DONE.
- Back-to-back I/O instructions: DONE loads the next one and re-enters BUSY directly, with no IDLE cycle between.
- `io_req` is a registered state decode: high from the first BUSY cycle until the edge that leaves BUSY.

## Test plan
- Reset mid-stream: pulse `resetn` low between edges → every output is at its reset value immediately, `io_req`=0, `io_err`=0.
- RAM store then load: `sw` to 0x00000010 with `eb`=0x12345678, then `lw` from the same address → `dmem_we` high for one cycle, `mmo`=0x12345678, `stall` never asserted.
- I/O read, ack on the 3rd BUSY cycle with `io_rdata`=0x000000A5 at address 0xFFFFFF04 → `io_addr`=0x04, `stall` high for 3 cycles, `mwreg` low during the stall, then DONE with `mmo`=0xA5 and `mwreg`=1 for one cycle.
- I/O write with an immediate ack → `io_we`=`io_req`=1 for exactly one cycle, `io_wdata`=`mb`, `dmem_we`=0 throughout.
- Timeout with TIMEOUT=4 and no ack → 4 stall cycles, then `mmo`=0xDEADBEEF and `io_err`=1 (stays set across later accesses until reset); a stray `io_ack` in IDLE has no effect.
- Back-to-back I/O loads, plus an ack in the final timeout cycle → second BUSY begins directly after DONE; the ack wins with `io_err` unchanged.

Source files
------------

// File: rtl/pipemem_io.sv
// Memory-access stage: EX/MEM register, data RAM routing,
// and a req/ack I/O window with timeout and pipeline stall.
module pipemem_io #(
  parameter logic [23:0] IO_BASE = 24'hFFFFFF,
  parameter int          TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  output logic [31:0] malu,
  output logic [31:0] mb,
  output logic [4:0]  mrn,
  output logic        mm2reg,
  output logic        mwreg,
  output logic [31:0] mmo,
  output logic        stall,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  input  logic [31:0] dmem_rdata,
  output logic [7:0]  io_addr,
  output logic [31:0] io_wdata,
  output logic        io_we,
  output logic        io_req,
  input  logic        io_ack,
  input  logic [31:0] io_rdata,
  output logic        io_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [31:0] rdbuf, rdbuf_n;
  logic        err_n;
  logic        mwreg_r;
  logic        mwmem;
  logic        mio;
  logic        eio;

  assign eio = (ealu[31:8] == IO_BASE) & (em2reg | ewmem);
  assign mio = (malu[31:8] == IO_BASE) & (mm2reg | mwmem);

  assign stall  = (state == BUSY);
  assign io_req = (state == BUSY);
  assign mwreg  = mwreg_r & ~stall;

  assign dmem_addr  = malu;
  assign dmem_wdata = mb;
  assign dmem_we    = mwmem & ~mio;

  assign io_addr  = malu[7:0];
  assign io_wdata = mb;
  assign io_we    = io_req & mwmem;

  assign mmo = mio ? rdbuf : dmem_rdata;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      malu    <= '0;
      mb      <= '0;
      mrn     <= '0;
      mwreg_r <= 1'b0;
      mm2reg  <= 1'b0;
      mwmem   <= 1'b0;
    end else if (!stall) begin
      malu    <= ealu;
      mb      <= eb;
      mrn     <= ern;
      mwreg_r <= ewreg;
      mm2reg  <= em2reg;
      mwmem   <= ewmem;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      rdbuf  <= '0;
      io_err <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rdbuf  <= rdbuf_n;
      io_err <= err_n;
    end
  end

  // ack beats the timeout when both land on the last BUSY cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rdbuf_n = rdbuf;
    err_n   = io_err;
    unique case (state)
      BUSY: begin
        if (io_ack) begin
          rdbuf_n = io_rdata;
          state_n = DONE;
        end else if (cnt == LAST) begin
          rdbuf_n = 32'hDEADBEEF;
          err_n   = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: begin
        if (eio) begin
          state_n = BUSY;
          cnt_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_pipemem_io.sv
// Scoreboard bench for pipemem_io: directed loads/stores to
// RAM and I/O, with a monitor checking every writeback.
module tb_pipemem_io;

  logic        clock;
  logic        resetn;
  logic [31:0] ealu, eb;
  logic [4:0]  ern;
  logic        ewreg, em2reg, ewmem;
  logic [31:0] malu, mb, mmo;
  logic [4:0]  mrn;
  logic        mm2reg, mwreg, stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we;
  logic [7:0]  io_addr;
  logic [31:0] io_wdata, io_rdata;
  logic        io_we, io_req, io_ack, io_err;

  pipemem_io #(.IO_BASE(24'hFFFFFF), .TIMEOUT(4)) dut (
    .clock(clock), .resetn(resetn),
    .ealu(ealu), .eb(eb), .ern(ern),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .malu(malu), .mb(mb), .mrn(mrn), .mm2reg(mm2reg),
    .mwreg(mwreg), .mmo(mmo), .stall(stall),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we),
    .io_req(io_req), .io_ack(io_ack), .io_rdata(io_rdata),
    .io_err(io_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // data RAM model, combinational read
  logic [31:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 32'hA0000000 + i;
  assign dmem_rdata = mem[dmem_addr[5:2]];
  always @(posedge clock) if (dmem_we) mem[dmem_addr[5:2]] <= dmem_wdata;

  // I/O device: acks on the ack_at-th BUSY cycle (0 = never)
  function automatic logic [31:0] rdata_of(input logic [7:0] a);
    return (a == 8'h04) ? 32'h000000A5 : {24'h5A5A5A, a};
  endfunction
  assign io_rdata = rdata_of(io_addr);

  int   ack_at = 0;
  int   bcnt = 0;
  logic stray = 1'b0;
  initial io_ack = 1'b0;
  always @(negedge clock) begin
    if (io_req) begin
      bcnt++;
      io_ack = (ack_at != 0) && (bcnt == ack_at);
    end else begin
      bcnt = 0;
      io_ack = stray;
    end
  end

  // scoreboard: {rn, data} per expected writeback
  logic [36:0] exp_q [$];
  int n_stall = 0;
  int n_dwe = 0;
  int n_iowe = 0;
  logic [31:0] last_iowd = '0;

  always @(negedge clock) begin
    if (resetn) begin
      if (stall) begin
        n_stall++;
        check("mwreg_in_stall", {31'd0, mwreg}, 32'd0);
      end
      if (dmem_we) n_dwe++;
      if (io_we) begin
        n_iowe++;
        last_iowd = io_wdata;
      end
      if (mwreg) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb", {27'd0, mrn}, 32'hFFFFFFFF);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          check("wb_rn", {27'd0, mrn}, {27'd0, e[36:32]});
          check("wb_data", mmo, e[31:0]);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rn, input logic w,
                       input logic l, input logic s_);
    int   n;
    logic s;
    ealu = a; eb = b; ern = rn;
    ewreg = w; em2reg = l; ewmem = s_;
    n = 0;
    do begin
      s = stall;
      @(posedge clock);
      @(negedge clock);
      n++;
    end while (s && n < 100);
    if (s) check("issue_timeout", 32'd1, 32'd0);
  endtask

  task automatic nop();
    issue(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    ealu = '0; eb = '0; ern = '0;
    ewreg = 1'b0; em2reg = 1'b0; ewmem = 1'b0;
    #3;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, io_req}, 32'd0);
    check("rst_mwreg", {31'd0, mwreg}, 32'd0);
    check("rst_dwe", {31'd0, dmem_we}, 32'd0);
    check("rst_mmo", mmo, 32'hA0000000);
    #4 resetn = 1'b1;
    @(negedge clock);

    // RAM store then load
    n_stall = 0; n_dwe = 0;
    issue(32'h10, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b1);
    check("sw_addr", dmem_addr, 32'h10);
    check("sw_wdata", dmem_wdata, 32'h12345678);
    exp_q.push_back({5'd5, 32'h12345678});
    issue(32'h10, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0);
    nop();
    check("ram_dwe_cnt", n_dwe, 32'd1);
    check("ram_stall", n_stall, 32'd0);

    // I/O read, ack on 3rd BUSY cycle
    ack_at = 3; n_stall = 0;
    exp_q.push_back({5'd7, 32'h000000A5});
    issue(32'hFFFFFF04, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    check("ior_addr", {24'd0, io_addr}, 32'h04);
    check("ior_req", {31'd0, io_req}, 32'd1);
    nop();
    check("ior_stall", n_stall, 32'd3);

    // I/O write, immediate ack
    ack_at = 1; n_stall = 0; n_dwe = 0; n_iowe = 0;
    issue(32'hFFFFFF08, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1);
    nop();
    check("iow_we_cnt", n_iowe, 32'd1);
    check("iow_wdata", last_iowd, 32'hCAFEF00D);
    check("iow_dwe", n_dwe, 32'd0);
    check("iow_stall", n_stall, 32'd1);

    // timeout, then stray ack in IDLE
    ack_at = 0; n_stall = 0;
    exp_q.push_back({5'd9, 32'hDEADBEEF});
    issue(32'hFFFFFF10, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    nop();
    check("to_stall", n_stall, 32'd4);
    check("to_err", {31'd0, io_err}, 32'd1);
    stray = 1'b1; n_stall = 0;
    exp_q.push_back({5'd3, 32'h12345678});
    issue(32'h10, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0);
    nop();
    stray = 1'b0;
    nop();
    check("stray_stall", n_stall, 32'd0);
    check("err_sticky", {31'd0, io_err}, 32'd1);

    // reset mid-stream, aborting a BUSY access
    issue(32'hFFFFFF30, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0);
    ealu = '0; ern = '0; ewreg = 1'b0; em2reg = 1'b0;
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    check("mid_req", {31'd0, io_req}, 32'd0);
    check("mid_stall", {31'd0, stall}, 32'd0);
    check("mid_err", {31'd0, io_err}, 32'd0);
    check("mid_mwreg", {31'd0, mwreg}, 32'd0);
    check("mid_mmo", mmo, 32'hA0000000);
    #1 resetn = 1'b1;
    @(negedge clock);

    // back-to-back I/O loads, ack on the final timeout cycle
    ack_at = 4; n_stall = 0;
    exp_q.push_back({5'd10, 32'h5A5A5A20});
    issue(32'hFFFFFF20, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({5'd11, 32'h5A5A5A24});
    issue(32'hFFFFFF24, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0);
    check("b2b_req", {31'd0, io_req}, 32'd1);
    nop();
    nop();
    check("b2b_stall", n_stall, 32'd8);
    check("b2b_err", {31'd0, io_err}, 32'd0);
    check("q_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
